// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad-to-BCD operand entry stage.
//   bcd_t     : one BCD digit
//   bcd4_t    : four packed BCD digits, [0] least significant
//   estado_t  : entry FSM states
//   TECLA_*   : keypad codes for the non-digit keys
package calc_pkg;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [3:0] bcd4_t;

  localparam logic [3:0] TECLA_SUMA   = 4'hA;
  localparam logic [3:0] TECLA_IGUAL  = 4'hB;
  localparam logic [3:0] TECLA_BORRAR = 4'hC;
  localparam logic [3:0] TECLA_RETRO  = 4'hD;

  typedef enum logic [2:0] {
    VACIO   = 3'd0,
    ENTRADA = 3'd1,
    ESPERA  = 3'd2,
    FIN_S   = 3'd3,
    FIN     = 3'd4
  } estado_t;

endpackage

// File: rtl/clasifica_tecla.sv
// Combinational key decoder.
//   tecla_valida, tecla : key strobe and code from the keypad scanner
//   es_digito .. es_retro : one-hot class of the key (all low when no strobe
//                           or for the unused codes 0xE/0xF)
module clasifica_tecla
  import calc_pkg::*;
(
  input  logic       tecla_valida,
  input  logic [3:0] tecla,
  output logic       es_digito,
  output logic       es_suma,
  output logic       es_igual,
  output logic       es_borrar,
  output logic       es_retro
);

  always_comb begin
    es_digito = tecla_valida && (tecla <= 4'd9);
    es_suma   = tecla_valida && (tecla == TECLA_SUMA);
    es_igual  = tecla_valida && (tecla == TECLA_IGUAL);
    es_borrar = tecla_valida && (tecla == TECLA_BORRAR);
    es_retro  = tecla_valida && (tecla == TECLA_RETRO);
  end

endmodule

// File: rtl/ingreso_numero.sv
// Turns keypad events into a packed BCD operand for the BCD adder and issues
// the accumulate (suma) and end-of-calculation (finalizar) strobes.
//   clk, rst          : clock, asynchronous active-low reset
//   tecla_valida/tecla: one-cycle key strobe and key code
//   clr               : clear request from the adder (level)
//   numero            : operand, digit [3] always 0
//   suma, finalizar   : one-cycle strobes, never high together
//   num_digitos, lleno: digits held / digit limit reached
//   ocupado           : waiting for the adder to clear us
//   estado            : current FSM state, for debug observation
// Handshake: tecla_valida is a single-cycle strobe with no back-pressure;
// keys arriving while busy (ESPERA, FIN_S) are dropped. All outputs are
// registered, so a key accepted in cycle N is visible in cycle N+1.
module ingreso_numero
  import calc_pkg::*;
#(
  parameter int MAX_DIGITOS = 3,
  parameter int TIMEOUT     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tecla_valida,
  input  logic [3:0] tecla,
  input  logic       clr,
  output bcd4_t      numero,
  output logic       suma,
  output logic       finalizar,
  output logic [1:0] num_digitos,
  output logic       lleno,
  output logic       ocupado,
  output estado_t    estado
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [1:0]    MAXD    = 2'(MAX_DIGITOS);

  logic es_digito, es_suma, es_igual, es_borrar, es_retro;

  clasifica_tecla u_clasifica (
    .tecla_valida (tecla_valida),
    .tecla        (tecla),
    .es_digito    (es_digito),
    .es_suma      (es_suma),
    .es_igual     (es_igual),
    .es_borrar    (es_borrar),
    .es_retro     (es_retro)
  );

  estado_t       estado_n;
  bcd4_t         numero_n;
  logic [1:0]    digitos_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          suma_n, fin_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado      <= VACIO;
      numero      <= '0;
      num_digitos <= '0;
      cnt         <= '0;
      suma        <= 1'b0;
      finalizar   <= 1'b0;
      lleno       <= 1'b0;
      ocupado     <= 1'b0;
    end else begin
      estado      <= estado_n;
      numero      <= numero_n;
      num_digitos <= digitos_n;
      cnt         <= cnt_n;
      suma        <= suma_n;
      finalizar   <= fin_n;
      lleno       <= (digitos_n == MAXD);
      ocupado     <= (estado_n == ESPERA);
    end
  end

  always_comb begin
    estado_n  = estado;
    numero_n  = numero;
    digitos_n = num_digitos;
    cnt_n     = '0;          // counter only runs while in ESPERA
    suma_n    = 1'b0;
    fin_n     = 1'b0;

    if (clr) begin
      // Adder clear wins over any key in the same cycle.
      estado_n  = VACIO;
      numero_n  = '0;
      digitos_n = '0;
    end else begin
      case (estado)
        ESPERA: begin
          if (cnt == CNT_MAX) begin
            estado_n  = VACIO;
            numero_n  = '0;
            digitos_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        FIN_S: begin
          fin_n    = 1'b1;
          estado_n = FIN;
        end
        default: begin  // VACIO, ENTRADA, FIN
          if (es_borrar) begin
            estado_n  = VACIO;
            numero_n  = '0;
            digitos_n = '0;
          end else if (es_digito) begin
            if (estado == FIN) begin
              // A digit after '=' starts a fresh operand.
              numero_n    = '0;
              numero_n[0] = tecla;
              digitos_n   = 2'd1;
              estado_n    = ENTRADA;
            end else if (num_digitos < MAXD) begin
              numero_n[2] = numero[1];
              numero_n[1] = numero[0];
              numero_n[0] = tecla;
              digitos_n   = num_digitos + 1'b1;
              estado_n    = ENTRADA;
            end
          end else if (es_retro && estado == ENTRADA) begin
            numero_n[0] = numero[1];
            numero_n[1] = numero[2];
            numero_n[2] = '0;
            digitos_n   = num_digitos - 1'b1;
            if (num_digitos == 2'd1) estado_n = VACIO;
          end else if (es_suma && estado == ENTRADA) begin
            suma_n   = 1'b1;
            estado_n = ESPERA;
          end else if (es_igual) begin
            if (estado == ENTRADA) begin
              suma_n   = 1'b1;
              estado_n = FIN_S;
            end else if (estado == VACIO) begin
              fin_n = 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ingreso_numero.sv
// Bench for ingreso_numero: directed steps followed by random key traffic,
// all compared against a digit-list model of the operand entry rules.
module tb_ingreso_numero;
  import calc_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int MAXD    = 3;

  // Model modes
  localparam int M_IDLE = 0, M_ENT = 1, M_WAIT = 2, M_FINP = 3, M_FIN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tecla_valida = 1'b0;
  logic [3:0] tecla = '0;
  logic       clr = 1'b0;
  bcd4_t      numero;
  logic       suma, finalizar, lleno, ocupado;
  logic [1:0] num_digitos;
  estado_t    estado;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int dq[$];
  int mode = M_IDLE;
  int wait_cnt = 0;
  bit e_suma = 0, e_fin = 0;

  ingreso_numero #(.MAX_DIGITOS(MAXD), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .tecla_valida (tecla_valida),
    .tecla        (tecla),
    .clr          (clr),
    .numero       (numero),
    .suma         (suma),
    .finalizar    (finalizar),
    .num_digitos  (num_digitos),
    .lleno        (lleno),
    .ocupado      (ocupado),
    .estado       (estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_numero();
    int val = 0;
    foreach (dq[i]) val = val * 10 + dq[i];
    return {4'd0, 4'((val / 100) % 10), 4'((val / 10) % 10), 4'(val % 10)};
  endfunction

  task automatic model_reset();
    dq.delete();
    mode = M_IDLE;
    wait_cnt = 0;
    e_suma = 0;
    e_fin = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] k, input logic c);
    e_suma = 0;
    e_fin  = 0;
    if (c) begin
      dq.delete();
      mode = M_IDLE;
      wait_cnt = 0;
    end else if (mode == M_WAIT) begin
      wait_cnt++;
      if (wait_cnt == TIMEOUT) begin
        dq.delete();
        mode = M_IDLE;
        wait_cnt = 0;
      end
    end else if (mode == M_FINP) begin
      e_fin = 1;
      mode = M_FIN;
    end else if (v) begin
      if (k <= 4'd9) begin
        if (mode == M_FIN) dq.delete();
        if (dq.size() < MAXD) begin
          dq.push_back(int'(k));
          mode = M_ENT;
        end
      end else if (k == 4'hA) begin
        if (mode == M_ENT) begin
          e_suma = 1;
          mode = M_WAIT;
          wait_cnt = 0;
        end
      end else if (k == 4'hB) begin
        if (mode == M_ENT) begin
          e_suma = 1;
          mode = M_FINP;
        end else if (mode == M_IDLE) begin
          e_fin = 1;
        end
      end else if (k == 4'hC) begin
        dq.delete();
        mode = M_IDLE;
      end else if (k == 4'hD) begin
        if (mode == M_ENT) begin
          void'(dq.pop_back());
          if (dq.size() == 0) mode = M_IDLE;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("numero",      32'(numero),      32'(exp_numero()));
    chk("suma",        32'(suma),        32'(e_suma));
    chk("finalizar",   32'(finalizar),   32'(e_fin));
    chk("num_digitos", 32'(num_digitos), 32'(dq.size()));
    chk("lleno",       32'(lleno),       32'(dq.size() == MAXD));
    chk("ocupado",     32'(ocupado),     32'(mode == M_WAIT));
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns after rising edge.
  task automatic step(input logic v, input logic [3:0] k, input logic c);
    @(negedge clk);
    tecla_valida = v;
    tecla = k;
    clr = c;
    @(posedge clk);
    model_step(v, k, c);
    #1;
    check_all();
    tecla_valida = 1'b0;
    clr = 1'b0;
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b1, k, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    // Clock/reset
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_estado", 32'(estado), 32'(VACIO));
    @(negedge clk);
    rst = 1'b1;

    // Three digits fill the operand; a fourth is ignored
    key(4'd1); key(4'd3); key(4'd5);
    chk("fill_numero", 32'(numero), 32'h0135);
    chk("fill_lleno", 32'(lleno), 32'd1);
    key(4'd7);
    chk("full_ignore", 32'(numero), 32'h0135);

    // '+' then adder clear two cycles later
    key(TECLA_BORRAR);
    key(4'd5); key(4'd6); key(4'd7);
    key(TECLA_SUMA);
    chk("plus_suma", 32'(suma), 32'd1);
    chk("plus_ocupado", 32'(ocupado), 32'd1);
    idle();
    chk("plus_suma_once", 32'(suma), 32'd0);
    step(1'b0, 4'h0, 1'b1);
    chk("clr_numero", 32'(numero), 32'h0);
    chk("clr_estado", 32'(estado), 32'(VACIO));

    // '+' with no clear: self-clear TIMEOUT cycles after the strobe
    key(4'd4);
    key(TECLA_SUMA);
    for (int i = 1; i < TIMEOUT; i++) begin
      idle();
      chk("timeout_hold", 32'(ocupado), 32'd1);
    end
    idle();
    chk("timeout_ocupado", 32'(ocupado), 32'd0);
    chk("timeout_numero", 32'(numero), 32'h0);

    // '=' gives suma then finalizar, operand held; next digit starts over
    key(4'd2); key(4'd9);
    key(TECLA_IGUAL);
    chk("eq_suma", 32'(suma), 32'd1);
    idle();
    chk("eq_fin", 32'(finalizar), 32'd1);
    chk("eq_hold", 32'(numero), 32'h0029);
    idle();
    key(4'd8);
    chk("fin_newdigit", 32'(numero), 32'h0008);
    chk("fin_count", 32'(num_digitos), 32'd1);

    // Backspace
    key(TECLA_BORRAR);
    key(4'd1); key(4'd2); key(4'd3);
    key(TECLA_RETRO); key(TECLA_RETRO);
    chk("retro_numero", 32'(numero), 32'h0001);
    key(TECLA_RETRO);
    chk("retro_empty", 32'(numero), 32'h0);
    chk("retro_estado", 32'(estado), 32'(VACIO));

    // '=' with nothing entered
    key(TECLA_IGUAL);
    chk("eq_empty_fin", 32'(finalizar), 32'd1);

    // clr and digit in the same cycle
    key(4'd6);
    step(1'b1, 4'd6, 1'b1);
    chk("clr_prio", 32'(numero), 32'h0);

    // Reset while in FIN_S: finalizar must never appear
    key(4'd2);
    key(TECLA_IGUAL);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("midreset_estado", 32'(estado), 32'(VACIO));
    @(posedge clk);
    #1;
    chk("midreset_fin", 32'(finalizar), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      logic       v, c;
      logic [3:0] k;
      v = ($urandom_range(0, 3) != 0);
      k = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      c = ($urandom_range(0, 24) == 0);
      step(v, k, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ingreso_numero.md
Name: ingreso_numero

Overview:
- Upstream stage of the BCD adder: turns keypad key events into a 4-digit packed BCD operand `numero`.
- Issues the `suma` / `finalizar` strobes the adder consumes.
- Honours the adder's clear request (`clr`, driven from the adder's `rst` output) after each accumulate.
- Sits between the keypad scanner and the adder; the adder's `numero` input is driven directly from this block.

Parameters:
- MAX_DIGITOS, 3, maximum digits accepted; digit[3] is always 0 so a sum cannot overflow 4 BCD digits.
- TIMEOUT, 16, cycles to wait for `clr` after `suma` before self-clearing.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- tecla_valida  input  1  one-cycle strobe from keypad scanner; `tecla` is valid in the same cycle.
- tecla  input  4  key code: 0x0-0x9 digit, 0xA '+', 0xB '=', 0xC clear, 0xD backspace, 0xE-0xF ignored.
- clr  input  1  clear request from adder; level, sampled each cycle.
- numero  output  [3:0][3:0]  packed BCD operand; [0] is least significant.
- suma  output  1  one-cycle accumulate strobe to adder.
- finalizar  output  1  one-cycle end-of-calculation strobe to adder.
- num_digitos  output  2  digits currently held, 0..MAX_DIGITOS.
- lleno  output  1  num_digitos == MAX_DIGITOS.
- ocupado  output  1  high while waiting for `clr` (state ESPERA).

Behaviour:
- Reset (rst=0, asynchronous): numero=0, suma=0, finalizar=0, num_digitos=0, lleno=0, ocupado=0, state VACIO, timeout counter=0.
- All outputs are registered. A key accepted in cycle N shows its effect on `numero` and the strobes in cycle N+1.
- States: VACIO, ENTRADA, ESPERA, FIN_S, FIN.
- Digit entry (VACIO/ENTRADA/FIN, count<MAX):
  - numero[2:1] <= numero[1:0]; numero[0] <= tecla; count+1.
  - numero[3] is never written (stays 0).
  - Next state ENTRADA.
  - In FIN, numero is first cleared, so the first digit lands in [0] with count=1.
- Digit while lleno: ignored, no state change.
- Backspace (ENTRADA): numero[1:0] <= numero[2:1]; numero[2] <= 0; count-1. If count becomes 0, go to VACIO. Ignored in other states.
- '+':
  - In ENTRADA: suma=1 for exactly one cycle, go to ESPERA.
  - In VACIO/FIN: ignored.
- '=':
  - In ENTRADA: suma=1 (cycle N+1), go to FIN_S; FIN_S then drives finalizar=1 (cycle N+2), go to FIN. No key is accepted in FIN_S.
  - In VACIO: finalizar=1 for one cycle, stay in VACIO.
  - In FIN: ignored.
- ESPERA:
  - All keys dropped.
  - Timeout counter increments each cycle.
  - On `clr`=1 or counter == TIMEOUT-1: numero=0, count=0, counter=0, go to VACIO.
- FIN: numero held. Clear key goes to VACIO with numero=0. `clr` behaves as in other states.
- Clear key (0xC), any state except ESPERA/FIN_S: numero=0, count=0, go to VACIO. Strobes stay 0.
- `clr`=1 in any state: numero=0, count=0, go to VACIO. `clr` has priority over a key in the same cycle; that key is dropped.
- Strobe rules:
  - suma and finalizar are never high in the same cycle.
  - Each strobe is high for exactly one cycle per event.
- Reset mid-sequence (e.g. in FIN_S): finalizar is never emitted; all outputs return to reset values immediately.
- Codes 0xE/0xF: no effect in any state.

Decomposition:
- Package calc_pkg:
  - bcd_t (logic [3:0]) and bcd4_t ([3:0] bcd_t packed).
  - Key-code localparams TECLA_SUMA=4'hA, TECLA_IGUAL=4'hB, TECLA_BORRAR=4'hC, TECLA_RETRO=4'hD.
  - enum estado_t {VACIO, ENTRADA, ESPERA, FIN_S, FIN}.
- One sub-module, clasifica_tecla (combinational): tecla + tecla_valida -> es_digito, es_suma, es_igual, es_borrar, es_retro, one-hot.
- FSM, shift register and timeout counter live in ingreso_numero.

Test Plan:
- Reset, then keys 1,3,5 -> numero={0,1,3,5}, num_digitos=3, lleno=1. A further key 7 -> numero unchanged.
- Enter 5,6,7 then '+' -> suma high exactly one cycle, ocupado=1. Assert clr two cycles later -> next cycle numero=0, state VACIO, ocupado=0.
- Enter 4 then '+' with clr never asserted -> ocupado drops and numero=0 exactly TIMEOUT (16) cycles after the suma strobe.
- Enter 2,9 then '=' -> suma in cycle N+1 and finalizar in cycle N+2, numero={0,0,2,9} held. Key 8 -> numero={0,0,0,8}, num_digitos=1.
- Enter 1,2,3 then backspace twice -> numero={0,0,0,1}, num_digitos=1; backspace again -> numero=0, state VACIO.
- clr and key 6 in the same cycle while in ENTRADA -> numero=0, key dropped. Pull rst low in FIN_S -> finalizar never asserts, all outputs 0.
